// File: rtl/zsram_pkg.sv
// Shared types and default timing for the ZSRAM access sequencer.
// Holds the FSM state encoding and the phase-counter reload helper.
package zsram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WSTROBE,
    WSETTLE,
    RSTROBE,
    RSETTLE,
    RESP
  } state_t;

  localparam int DEFAULT_ADDR_W        = 4;
  localparam int DEFAULT_DATA_W        = 8;
  localparam int DEFAULT_STROBE_CYCLES = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 3;
  localparam int PHASE_W               = 4;

  // The phase counter counts down to zero, so a phase of N cycles reloads N-1.
  function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
    return PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/zsram_edge_decoder.sv
// Turns a word address plus an enable into a one-hot edge vector for the bank.
module zsram_edge_decoder
#(
  parameter int ADDR_W = 4
)
(
  input  logic [ADDR_W-1:0]    address,
  input  logic                 enable,
  output logic [2**ADDR_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot[address] = 1'b1;
    end
  end

endmodule

// File: rtl/zsram_access_sequencer.sv
// Sequences single-word reads and writes onto an edge-triggered SRAM bank.
// Define ZSRAM_READBACK_VERIFY_EN to read back every write and flag mismatches on RspError.
module zsram_access_sequencer
  import zsram_pkg::*;
#(
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
)
(
  input  logic                 Crystal50Mhz1,
  input  logic                 Reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDR_W-1:0]    ReqAddr,
  input  logic [DATA_W-1:0]    ReqData,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [DATA_W-1:0]    RspData,
  output logic                 RspError,
  output logic [2**ADDR_W-1:0] CellWriteEdge,
  output logic [2**ADDR_W-1:0] CellReadEdge,
  output logic [DATA_W-1:0]    CellInputData,
  input  logic [DATA_W-1:0]    CellOutputData
);

  localparam logic [PHASE_W-1:0] STROBE_LOAD = phase_load(STROBE_CYCLES);
  localparam logic [PHASE_W-1:0] SETTLE_LOAD = phase_load(SETTLE_CYCLES);

  state_t              state;
  logic [PHASE_W-1:0]  phase;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_strobe;
  logic                rd_strobe;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;

`ifdef ZSRAM_READBACK_VERIFY_EN
  logic                rsp_error;
`endif

  // Ready is gated by Reset so it drops during reset yet rises in the very
  // first cycle that Reset is low again.
  assign ReqReady      = (state == IDLE) && !Reset;
  assign RspValid      = rsp_valid;
  assign RspData       = rsp_data;
  assign CellInputData = data_q;

`ifdef ZSRAM_READBACK_VERIFY_EN
  assign RspError = rsp_error;
`else
  assign RspError = 1'b0;
`endif

  // Strobe flags are mutually exclusive, so at most one edge bit is ever high.
  zsram_edge_decoder #(.ADDR_W(ADDR_W)) u_write_decoder (
    .address (addr_q),
    .enable  (wr_strobe),
    .onehot  (CellWriteEdge)
  );

  zsram_edge_decoder #(.ADDR_W(ADDR_W)) u_read_decoder (
    .address (addr_q),
    .enable  (rd_strobe),
    .onehot  (CellReadEdge)
  );

  always_ff @(posedge Crystal50Mhz1) begin
    if (Reset) begin
      state     <= IDLE;
      phase     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef ZSRAM_READBACK_VERIFY_EN
      rsp_error <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            write_q <= ReqWrite;
            addr_q  <= ReqAddr;
            data_q  <= ReqData;
            phase   <= '0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          phase <= STROBE_LOAD;
          if (write_q) begin
            wr_strobe <= 1'b1;
            state     <= WSTROBE;
          end else begin
            rd_strobe <= 1'b1;
            state     <= RSTROBE;
          end
        end

        WSTROBE: begin
          if (phase == '0) begin
            wr_strobe <= 1'b0;
            phase     <= SETTLE_LOAD;
            state     <= WSETTLE;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        WSETTLE: begin
          if (phase == '0) begin
`ifdef ZSRAM_READBACK_VERIFY_EN
            rd_strobe <= 1'b1;
            phase     <= STROBE_LOAD;
            state     <= RSTROBE;
`else
            rsp_valid <= 1'b1;
            rsp_data  <= data_q;
            state     <= RESP;
`endif
          end else begin
            phase <= phase - 1'b1;
          end
        end

        RSTROBE: begin
          if (phase == '0) begin
            rd_strobe <= 1'b0;
            phase     <= SETTLE_LOAD;
            state     <= RSETTLE;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        // The bank output has settled by the last cycle here, so sample it now.
        RSETTLE: begin
          if (phase == '0) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef ZSRAM_READBACK_VERIFY_EN
            if (write_q) begin
              rsp_data  <= data_q;
              rsp_error <= (CellOutputData != data_q);
            end else begin
              rsp_data  <= CellOutputData;
              rsp_error <= 1'b0;
            end
`else
            rsp_data <= CellOutputData;
`endif
          end else begin
            phase <= phase - 1'b1;
          end
        end

        RESP: begin
          if (RspReady) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zsram_access_sequencer.sv
// Self-checking bench for zsram_access_sequencer: transaction-level timing model plus bank emulation.
// Honours ZSRAM_READBACK_VERIFY_EN the same way the design does.
module tb_zsram_access_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int S  = 2;
  localparam int T  = 3;

`ifdef ZSRAM_READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int RESP_READ  = 2 + S + T;
  localparam int RESP_WRITE = VERIFY ? (2 + 2 * (S + T)) : (2 + S + T);

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic          ReqWrite = 1'b0;
  logic [AW-1:0] ReqAddr = '0;
  logic [DW-1:0] ReqData = '0;
  logic          RspValid;
  logic          RspReady = 1'b0;
  logic [DW-1:0] RspData;
  logic          RspError;
  logic [15:0]   CellWriteEdge;
  logic [15:0]   CellReadEdge;
  logic [DW-1:0] CellInputData;
  logic [DW-1:0] bankOut = '0;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  zsram_access_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S), .SETTLE_CYCLES(T)
  ) dut (
    .Crystal50Mhz1  (clk),
    .Reset          (Reset),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .ReqWrite       (ReqWrite),
    .ReqAddr        (ReqAddr),
    .ReqData        (ReqData),
    .RspValid       (RspValid),
    .RspReady       (RspReady),
    .RspData        (RspData),
    .RspError       (RspError),
    .CellWriteEdge  (CellWriteEdge),
    .CellReadEdge   (CellReadEdge),
    .CellInputData  (CellInputData),
    .CellOutputData (bankOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
  endtask

  // Bank emulation: edge-triggered cells, output holds after a read edge.
  logic [DW-1:0] bank [16] = '{default: '0};
  logic [DW-1:0] corruptMask = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (CellWriteEdge[i]) bank[i] <= CellInputData;
      if (CellReadEdge[i])  bankOut <= bank[i] ^ corruptMask;
    end
  end

  // Reference model: one transaction in flight, timed by cycles since acceptance.
  logic [DW-1:0] refMem [16] = '{default: '0};
  bit            mBusy = 1'b0;
  bit            modelLive = 1'b0;
  int            mT = 0;
  int            mRespStart = 0;
  int            acceptCount = 0;
  logic          mWrite = 1'b0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mCin = '0;
  logic [DW-1:0] mData = '0;
  logic [DW-1:0] mRespData = '0;
  logic          mErr = 1'b0;
  logic          mRespErr = 1'b0;

  always @(posedge clk) begin
    if (Reset) begin
      mBusy = 1'b0; mData = '0; mErr = 1'b0; mCin = '0; modelLive = 1'b1;
    end else if (!mBusy) begin
      if (ReqValid) begin
        mBusy = 1'b1; mT = 1; mWrite = ReqWrite; mAddr = ReqAddr; mCin = ReqData;
        acceptCount++;
        mRespStart = ReqWrite ? RESP_WRITE : RESP_READ;
        if (ReqWrite) begin
          refMem[ReqAddr] = ReqData;
          mRespData = ReqData;
          mRespErr  = VERIFY && (corruptMask != '0);
        end else begin
          mRespData = refMem[ReqAddr] ^ corruptMask;
          mRespErr  = 1'b0;
        end
      end
    end else if (mT >= mRespStart) begin
      if (RspReady) mBusy = 1'b0;
    end else begin
      mT++;
      if (mT == mRespStart) begin
        mData = mRespData;
        mErr  = mRespErr;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelLive) begin
      logic [15:0] expW;
      logic [15:0] expR;
      expW = '0;
      expR = '0;
      if (mBusy && mWrite && mT >= 2 && mT <= 1 + S) expW = 16'(1) << mAddr;
      if (mBusy && !mWrite && mT >= 2 && mT <= 1 + S) expR = 16'(1) << mAddr;
      if (VERIFY && mBusy && mWrite && mT >= 2 + S + T && mT <= 1 + 2 * S + T) expR = 16'(1) << mAddr;
      checkOutput("ReqReady", 32'(ReqReady), 32'(!mBusy && !Reset));
      checkOutput("RspValid", 32'(RspValid), 32'(mBusy && mT >= mRespStart));
      checkOutput("CellWriteEdge", 32'(CellWriteEdge), 32'(expW));
      checkOutput("CellReadEdge", 32'(CellReadEdge), 32'(expR));
      checkOutput("CellInputData", 32'(CellInputData), 32'(mCin));
      checkOutput("RspData", 32'(RspData), 32'(mData));
      checkOutput("RspError", 32'(RspError), 32'(mErr));
      checkOutput("edgeOneHot", 32'($countones({CellWriteEdge, CellReadEdge}) <= 1), 32'd1);
    end
  end

  int cyc = 0;

  task automatic stepNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic goToCycle(input int k);
    while (cyc < k) begin
      stepNeg();
      cyc++;
    end
  endtask

  // Presents one request, waits for acceptance, and leaves the bench in cycle 1.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqData = d;
    n = 0;
    while (!ReqReady && n < 100) begin
      stepNeg();
      n++;
    end
    if (n >= 100) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    stepNeg();
    ReqValid = 1'b0;
    cyc = 1;
  endtask

  task automatic finishResponse();
    RspReady = 1'b1;
    stepNeg();
    RspReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done;
    int cycles;
    int lastAccept;

    $display("[TB] start, readback verify = %0d", VERIFY);
    repeat (3) stepNeg();
    checkOutput("rstReqReady", 32'(ReqReady), 32'd0);
    checkOutput("rstRspValid", 32'(RspValid), 32'd0);
    checkOutput("rstRspData", 32'(RspData), 32'd0);
    checkOutput("rstCellIn", 32'(CellInputData), 32'd0);
    checkOutput("rstEdges", 32'({CellWriteEdge, CellReadEdge}), 32'd0);
    Reset = 1'b0;
    stepNeg();

    // Write 0xA5 to word 3.
    applyStimulus(1'b1, 4'd3, 8'hA5);
    checkOutput("wrSetupEdge", 32'(CellWriteEdge), 32'h0);
    checkOutput("wrSetupData", 32'(CellInputData), 32'hA5);
    goToCycle(2);
    checkOutput("wrStrobeC2", 32'(CellWriteEdge), 32'h0008);
    goToCycle(3);
    checkOutput("wrStrobeC3", 32'(CellWriteEdge), 32'h0008);
    goToCycle(4);
    checkOutput("wrStrobeC4", 32'(CellWriteEdge), 32'h0);
    goToCycle(RESP_WRITE - 1);
    checkOutput("wrNoRspEarly", 32'(RspValid), 32'd0);
    goToCycle(RESP_WRITE);
    checkOutput("wrRspValid", 32'(RspValid), 32'd1);
    checkOutput("wrRspData", 32'(RspData), 32'hA5);
    finishResponse();

    // Read word 3 back.
    applyStimulus(1'b0, 4'd3, 8'h00);
    goToCycle(2);
    checkOutput("rdStrobeC2", 32'(CellReadEdge), 32'h0008);
    goToCycle(3);
    checkOutput("rdStrobeC3", 32'(CellReadEdge), 32'h0008);
    goToCycle(7);
    checkOutput("rdRspValidC7", 32'(RspValid), 32'd1);
    checkOutput("rdRspDataC7", 32'(RspData), 32'hA5);
    finishResponse();

`ifdef ZSRAM_READBACK_VERIFY_EN
    // Readback returns 0x5B for a written 0x5A.
    corruptMask = 8'h01;
    applyStimulus(1'b1, 4'd3, 8'h5A);
    goToCycle(7);
    checkOutput("vfyRdC7", 32'(CellReadEdge), 32'h0008);
    goToCycle(8);
    checkOutput("vfyRdC8", 32'(CellReadEdge), 32'h0008);
    goToCycle(11);
    checkOutput("vfyNoRspC11", 32'(RspValid), 32'd0);
    goToCycle(12);
    checkOutput("vfyRspValidC12", 32'(RspValid), 32'd1);
    checkOutput("vfyRspError", 32'(RspError), 32'd1);
    checkOutput("vfyRspData", 32'(RspData), 32'h5A);
    finishResponse();
    corruptMask = 8'h00;
`endif

    // Consumer stalls for 10 cycles while a new request waits.
    applyStimulus(1'b0, 4'd3, 8'h00);
    goToCycle(7);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'd7; ReqData = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      checkOutput("holdRspValid", 32'(RspValid), 32'd1);
      checkOutput("holdRspData", 32'(RspData), VERIFY ? 32'h5A : 32'hA5);
      checkOutput("holdReqReady", 32'(ReqReady), 32'd0);
      stepNeg();
    end
    RspReady = 1'b1;
    stepNeg();
    RspReady = 1'b0;
    checkOutput("afterHsReqReady", 32'(ReqReady), 32'd1);
    checkOutput("afterHsRspValid", 32'(RspValid), 32'd0);
    @(posedge clk);
    stepNeg();
    ReqValid = 1'b0;
    cyc = 1;
    goToCycle(2);
    checkOutput("b2bWrEdge", 32'(CellWriteEdge), 32'h0080);
    goToCycle(RESP_WRITE);
    checkOutput("b2bRspData", 32'(RspData), 32'h3C);
    finishResponse();

    // Reset in cycle 2 of a write.
    applyStimulus(1'b1, 4'd3, 8'hC3);
    goToCycle(2);
    checkOutput("rstMidEdgeBefore", 32'(CellWriteEdge), 32'h0008);
    Reset = 1'b1;
    stepNeg();
    checkOutput("rstMidEdgeAfter", 32'(CellWriteEdge), 32'h0);
    checkOutput("rstMidRspValid", 32'(RspValid), 32'd0);
    Reset = 1'b0;
    #1;
    checkOutput("rstMidReady", 32'(ReqReady), 32'd1);
    for (int k = 0; k < 10; k++) begin
      stepNeg();
      checkOutput("rstNoRsp", 32'(RspValid), 32'd0);
    end

    // Random request stream; the compare process checks every cycle.
    done = 0;
    cycles = 0;
    lastAccept = acceptCount;
    while (done < 150 && cycles < 20000) begin
      stepNeg();
      cycles++;
      RspReady = ($urandom_range(0, 3) != 0);
      if (ReqValid && acceptCount != lastAccept) begin
        ReqValid = 1'b0;
        done++;
      end
      if (!ReqValid && !mBusy && $urandom_range(0, 2) != 0) begin
        lastAccept  = acceptCount;
        corruptMask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        ReqWrite    = 1'($urandom_range(0, 1));
        ReqAddr     = 4'($urandom_range(0, 15));
        ReqData     = 8'($urandom);
        ReqValid    = 1'b1;
      end
    end
    checkOutput("randomStreamDone", 32'(done), 32'd150);
    RspReady = 1'b1;
    for (int k = 0; k < 40 && mBusy; k++) stepNeg();
    RspReady = 1'b0;
    repeat (3) stepNeg();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/zsram_access_sequencer.md
ZSRAM_ACCESS_SEQUENCER -- requirements
Module: zsram_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: word address width; bank depth is 2**ADDR_W cells.
REQ-002 SHALL have parameter DATA_W, default 8: bits per word.
REQ-003 SHALL have parameter STROBE_CYCLES, default 2: edge pulse width in clocks, legal range 1..15.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 3: post-strobe settle time in clocks, legal range 1..15.
REQ-005 SHALL have port Crystal50Mhz1, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ReqValid, input, 1 bit: an access request is present.
REQ-008 SHALL have port ReqReady, output, 1 bit: the sequencer accepts a request this cycle.
REQ-009 SHALL have port ReqWrite, input, 1 bit: 1 requests a write, 0 requests a read.
REQ-010 SHALL have port ReqAddr, input, ADDR_W bits: target word.
REQ-011 SHALL have port ReqData, input, DATA_W bits: write data.
REQ-012 SHALL have port RspValid, output, 1 bit: a response is present.
REQ-013 SHALL have port RspReady, input, 1 bit: the consumer accepts the response.
REQ-014 SHALL have port RspData, output, DATA_W bits: read data, or the written data for a write.
REQ-015 SHALL have port RspError, output, 1 bit: readback mismatch (see Configuration).
REQ-016 SHALL have port CellWriteEdge, output, 2**ADDR_W bits: one-hot WriteEdge to each cell word.
REQ-017 SHALL have port CellReadEdge, output, 2**ADDR_W bits: one-hot ReadEdge to each cell word.
REQ-018 SHALL have port CellInputData, output, DATA_W bits: shared inputData bus to the bank.
REQ-019 SHALL have port CellOutputData, input, DATA_W bits: shared outputData bus from the bank.

Function
REQ-020 SHALL implement the FSM states IDLE, SETUP, WSTROBE, WSETTLE, RSTROBE, RSETTLE and RESP.
REQ-021 SHALL drive ReqReady=1 only in IDLE; a request is accepted when ReqValid&&ReqReady, which latches ReqWrite, ReqAddr and ReqData and moves the FSM to SETUP.
REQ-022 SHALL spend exactly one cycle in SETUP, driving CellInputData = latched data with all edges 0; from SETUP the FSM goes to WSTROBE for a write and RSTROBE for a read.
REQ-023 SHALL, in WSTROBE and RSTROBE, assert only the addressed bit of CellWriteEdge or CellReadEdge respectively, for exactly STROBE_CYCLES cycles.
REQ-024 SHALL hold all edge outputs at 0 in the SETTLE states, which last SETTLE_CYCLES cycles each.
REQ-025 SHALL capture CellOutputData into RspData on the last RSETTLE cycle.
REQ-026 SHALL never assert CellReadEdge and CellWriteEdge in the same cycle, and SHALL never assert more than one bit of either.
REQ-027 SHALL keep the address and CellInputData stable from SETUP through the final SETTLE state.
REQ-028 SHALL, in RESP, hold RspValid=1 with RspData and RspError stable until RspReady=1, then return to IDLE; back-to-back requests are accepted at the earliest in the cycle following the handshake.
REQ-029 SHALL set RspData to the latched write data for a write.
REQ-030 SHALL keep the phase counter at 4 bits; it reloads on each state entry and never wraps.

Reset
REQ-031 SHALL, while Reset=1 at a clock edge, force state IDLE, all edges 0, ReqReady=0, RspValid=0, RspData=0, RspError=0, CellInputData=0 and counters 0.
REQ-032 SHALL, on Reset mid-operation, drop any active strobe by the next edge and discard the in-flight request with no response; ReqReady=1 from the first cycle after Reset deasserts.

Configuration
REQ-033 SHALL, with ZSRAM_READBACK_VERIFY_EN defined, follow WSETTLE with RSTROBE then RSETTLE for the same address, compare the captured data to the written data, and set RspError=1 on mismatch.
REQ-034 SHALL, with ZSRAM_READBACK_VERIFY_EN undefined, go from WSETTLE directly to RESP, and tie RspError to 0.

Structure
REQ-035 SHALL place the FSM state enum and the default timing constants in package zsram_pkg.
REQ-036 SHALL implement the one-hot edge generation as sub-module zsram_edge_decoder (inputs: address, enable; output: one-hot vector).

Verification (defaults; request accepted in cycle 0)
REQ-037 SHALL cover: write addr 3, data 0xA5, verify off -> CellWriteEdge=0x0008 in cycles 2-3, RspValid=1 from cycle 7, RspData=0xA5.
REQ-038 SHALL cover: read addr 3 with the bank model returning 0xA5 -> CellReadEdge=0x0008 in cycles 2-3, RspData=0xA5 at cycle 7.
REQ-039 SHALL cover: verify on, write 0x5A with the model returning 0x5B -> read strobe in cycles 7-8, RspValid at cycle 12, RspError=1.
REQ-040 SHALL cover: RspReady held 0 for 10 cycles -> RspValid and RspData stable, ReqReady=0 throughout, with a new request accepted the cycle after RspReady=1.
REQ-041 SHALL cover: Reset asserted in cycle 2 of a write -> CellWriteEdge=0 at the next edge, no RspValid, ReqReady=1 after Reset releases.
REQ-042 SHALL cover: a random request stream -> assertion that no two edge bits are ever high together.
